// File: rtl/alu_reservation_station.sv
// Reservation station for ALU/branch/jump instructions: holds dispatched entries,
// snoops ALU/LSU bypass buses for missing operands, issues one ready entry per cycle.
module alu_reservation_station #(
  parameter int unsigned RS_SIZE  = 16,
  parameter int unsigned RS_IDX_W = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ROB_W    = 4,
  parameter int unsigned INS_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rob2rs_clear,
  input  logic              dsp2rs_enable,
  input  logic [INS_W-1:0]  dsp2rs_ins_type,
  input  logic              dsp2rs_rs1_valid,
  input  logic [DATA_W-1:0] dsp2rs_rs1_value,
  input  logic [ROB_W-1:0]  dsp2rs_rs1_tag,
  input  logic              dsp2rs_rs2_valid,
  input  logic [DATA_W-1:0] dsp2rs_rs2_value,
  input  logic [ROB_W-1:0]  dsp2rs_rs2_tag,
  input  logic [DATA_W-1:0] dsp2rs_imm,
  input  logic [ADDR_W-1:0] dsp2rs_pc,
  input  logic [ROB_W-1:0]  dsp2rs_reorder,
  input  logic              alu2rs_bypass_enable,
  input  logic [ROB_W-1:0]  alu2rs_bypass_reorder,
  input  logic [DATA_W-1:0] alu2rs_bypass_value,
  input  logic              lsu2rs_bypass_enable,
  input  logic [ROB_W-1:0]  lsu2rs_bypass_reorder,
  input  logic [DATA_W-1:0] lsu2rs_bypass_value,
  output logic              rs2dsp_full,
  output logic              rs2alu_enable,
  output logic [INS_W-1:0]  rs2alu_ins_type,
  output logic [DATA_W-1:0] rs2alu_rs1,
  output logic [DATA_W-1:0] rs2alu_rs2,
  output logic [DATA_W-1:0] rs2alu_imm,
  output logic [ADDR_W-1:0] rs2alu_pc,
  output logic [ROB_W-1:0]  rs2alu_reorder
);

  typedef struct packed {
    logic              busy;
    logic [INS_W-1:0]  ins_type;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [ROB_W-1:0]  reorder;
    logic              rs1_valid;
    logic [DATA_W-1:0] rs1_value;
    logic [ROB_W-1:0]  rs1_tag;
    logic              rs2_valid;
    logic [DATA_W-1:0] rs2_value;
    logic [ROB_W-1:0]  rs2_tag;
  } rs_entry_t;

  rs_entry_t             ent [RS_SIZE];
  logic [RS_SIZE-1:0]    busy_vec;
  logic [RS_SIZE-1:0]    ready_vec;
  logic                  free_found;
  logic [RS_IDX_W-1:0]   free_idx;
  logic                  rdy_found;
  logic [RS_IDX_W-1:0]   rdy_idx;

  // Resolve an operand against the bypass buses; ALU takes priority over LSU.
  function automatic logic [DATA_W:0] snoop(input logic              valid,
                                            input logic [DATA_W-1:0] value,
                                            input logic [ROB_W-1:0]  tag);
    if (valid)
      return {1'b1, value};
    else if (alu2rs_bypass_enable && (alu2rs_bypass_reorder == tag))
      return {1'b1, alu2rs_bypass_value};
    else if (lsu2rs_bypass_enable && (lsu2rs_bypass_reorder == tag))
      return {1'b1, lsu2rs_bypass_value};
    else
      return {1'b0, value};
  endfunction

  // Busy/ready vectors and lowest-index free and ready entry selection.
  always_comb begin
    busy_vec   = '0;
    ready_vec  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy & ent[i].rs1_valid & ent[i].rs2_valid;
      if (!busy_vec[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
      if (ready_vec[i] && !rdy_found) begin
        rdy_found = 1'b1;
        rdy_idx   = RS_IDX_W'(i);
      end
    end
  end

  assign rs2dsp_full = &busy_vec;

  // Entry storage: clear, then wakeup, issue and dispatch on disjoint entries/fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RS_SIZE); i++) ent[i] <= '0;
    end else if (rob2rs_clear) begin
      for (int i = 0; i < int'(RS_SIZE); i++) ent[i].busy <= 1'b0;
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (ent[i].busy) begin
          {ent[i].rs1_valid, ent[i].rs1_value} <=
            snoop(ent[i].rs1_valid, ent[i].rs1_value, ent[i].rs1_tag);
          {ent[i].rs2_valid, ent[i].rs2_value} <=
            snoop(ent[i].rs2_valid, ent[i].rs2_value, ent[i].rs2_tag);
        end
      end
      if (rdy_found) ent[rdy_idx].busy <= 1'b0;
      if (dsp2rs_enable && free_found) begin
        ent[free_idx].busy     <= 1'b1;
        ent[free_idx].ins_type <= dsp2rs_ins_type;
        ent[free_idx].imm      <= dsp2rs_imm;
        ent[free_idx].pc       <= dsp2rs_pc;
        ent[free_idx].reorder  <= dsp2rs_reorder;
        ent[free_idx].rs1_tag  <= dsp2rs_rs1_tag;
        ent[free_idx].rs2_tag  <= dsp2rs_rs2_tag;
        {ent[free_idx].rs1_valid, ent[free_idx].rs1_value} <=
          snoop(dsp2rs_rs1_valid, dsp2rs_rs1_value, dsp2rs_rs1_tag);
        {ent[free_idx].rs2_valid, ent[free_idx].rs2_value} <=
          snoop(dsp2rs_rs2_valid, dsp2rs_rs2_value, dsp2rs_rs2_tag);
      end
    end
  end

  // Registered issue port; zeroed whenever nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs2alu_enable   <= 1'b0;
      rs2alu_ins_type <= '0;
      rs2alu_rs1      <= '0;
      rs2alu_rs2      <= '0;
      rs2alu_imm      <= '0;
      rs2alu_pc       <= '0;
      rs2alu_reorder  <= '0;
    end else if (rob2rs_clear || !rdy_found) begin
      rs2alu_enable   <= 1'b0;
      rs2alu_ins_type <= '0;
      rs2alu_rs1      <= '0;
      rs2alu_rs2      <= '0;
      rs2alu_imm      <= '0;
      rs2alu_pc       <= '0;
      rs2alu_reorder  <= '0;
    end else begin
      rs2alu_enable   <= 1'b1;
      rs2alu_ins_type <= ent[rdy_idx].ins_type;
      rs2alu_rs1      <= ent[rdy_idx].rs1_value;
      rs2alu_rs2      <= ent[rdy_idx].rs2_value;
      rs2alu_imm      <= ent[rdy_idx].imm;
      rs2alu_pc       <= ent[rdy_idx].pc;
      rs2alu_reorder  <= ent[rdy_idx].reorder;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob2rs_clear;
  logic        dsp2rs_enable;
  logic [5:0]  dsp2rs_ins_type;
  logic        dsp2rs_rs1_valid;
  logic [31:0] dsp2rs_rs1_value;
  logic [3:0]  dsp2rs_rs1_tag;
  logic        dsp2rs_rs2_valid;
  logic [31:0] dsp2rs_rs2_value;
  logic [3:0]  dsp2rs_rs2_tag;
  logic [31:0] dsp2rs_imm;
  logic [31:0] dsp2rs_pc;
  logic [3:0]  dsp2rs_reorder;
  logic        alu2rs_bypass_enable;
  logic [3:0]  alu2rs_bypass_reorder;
  logic [31:0] alu2rs_bypass_value;
  logic        lsu2rs_bypass_enable;
  logic [3:0]  lsu2rs_bypass_reorder;
  logic [31:0] lsu2rs_bypass_value;
  logic        rs2dsp_full;
  logic        rs2alu_enable;
  logic [5:0]  rs2alu_ins_type;
  logic [31:0] rs2alu_rs1;
  logic [31:0] rs2alu_rs2;
  logic [31:0] rs2alu_imm;
  logic [31:0] rs2alu_pc;
  logic [3:0]  rs2alu_reorder;

  int compared = 0;
  int mismatched = 0;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .rob2rs_clear(rob2rs_clear),
    .dsp2rs_enable(dsp2rs_enable), .dsp2rs_ins_type(dsp2rs_ins_type),
    .dsp2rs_rs1_valid(dsp2rs_rs1_valid), .dsp2rs_rs1_value(dsp2rs_rs1_value),
    .dsp2rs_rs1_tag(dsp2rs_rs1_tag), .dsp2rs_rs2_valid(dsp2rs_rs2_valid),
    .dsp2rs_rs2_value(dsp2rs_rs2_value), .dsp2rs_rs2_tag(dsp2rs_rs2_tag),
    .dsp2rs_imm(dsp2rs_imm), .dsp2rs_pc(dsp2rs_pc), .dsp2rs_reorder(dsp2rs_reorder),
    .alu2rs_bypass_enable(alu2rs_bypass_enable), .alu2rs_bypass_reorder(alu2rs_bypass_reorder),
    .alu2rs_bypass_value(alu2rs_bypass_value),
    .lsu2rs_bypass_enable(lsu2rs_bypass_enable), .lsu2rs_bypass_reorder(lsu2rs_bypass_reorder),
    .lsu2rs_bypass_value(lsu2rs_bypass_value),
    .rs2dsp_full(rs2dsp_full), .rs2alu_enable(rs2alu_enable),
    .rs2alu_ins_type(rs2alu_ins_type), .rs2alu_rs1(rs2alu_rs1), .rs2alu_rs2(rs2alu_rs2),
    .rs2alu_imm(rs2alu_imm), .rs2alu_pc(rs2alu_pc), .rs2alu_reorder(rs2alu_reorder)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a dispatch on the inputs (takes effect on the next edge).
  task automatic drive_dispatch(input logic [5:0] typ,
                                input logic v1, input logic [31:0] val1, input logic [3:0] tag1,
                                input logic v2, input logic [31:0] val2, input logic [3:0] tag2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [3:0] rob);
    dsp2rs_enable    = 1'b1;
    dsp2rs_ins_type  = typ;
    dsp2rs_rs1_valid = v1;
    dsp2rs_rs1_value = val1;
    dsp2rs_rs1_tag   = tag1;
    dsp2rs_rs2_valid = v2;
    dsp2rs_rs2_value = val2;
    dsp2rs_rs2_tag   = tag2;
    dsp2rs_imm       = imm;
    dsp2rs_pc        = pc;
    dsp2rs_reorder   = rob;
  endtask

  task automatic idle_inputs();
    rob2rs_clear          = 1'b0;
    dsp2rs_enable         = 1'b0;
    dsp2rs_ins_type       = '0;
    dsp2rs_rs1_valid      = 1'b0;
    dsp2rs_rs1_value      = '0;
    dsp2rs_rs1_tag        = '0;
    dsp2rs_rs2_valid      = 1'b0;
    dsp2rs_rs2_value      = '0;
    dsp2rs_rs2_tag        = '0;
    dsp2rs_imm            = '0;
    dsp2rs_pc             = '0;
    dsp2rs_reorder        = '0;
    alu2rs_bypass_enable  = 1'b0;
    alu2rs_bypass_reorder = '0;
    alu2rs_bypass_value   = '0;
    lsu2rs_bypass_enable  = 1'b0;
    lsu2rs_bypass_reorder = '0;
    lsu2rs_bypass_value   = '0;
  endtask

  task automatic flush();
    rob2rs_clear = 1'b1;
    step();
    rob2rs_clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    compared++;
    if (rs2alu_enable !== 1'b0 || rs2alu_rs1 !== 32'd0 || rs2alu_imm !== 32'd0 ||
        rs2alu_pc !== 32'd0 || rs2alu_reorder !== 4'd0 || rs2alu_ins_type !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: en=%b rs1=%h imm=%h pc=%h rob=%h required all 0",
               rs2alu_enable, rs2alu_rs1, rs2alu_imm, rs2alu_pc, rs2alu_reorder);
    end
    compared++;
    if (rs2dsp_full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_full: got %b required 0", rs2dsp_full);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ready_dispatch();
    drive_dispatch(6'h01, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7, 32'h100, 4'd2);
    step();
    idle_inputs();
    compared++;
    if (rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL addi_no_early_issue: en=%b required 0", rs2alu_enable);
    end
    step();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_rs1 !== 32'd5 || rs2alu_imm !== 32'd7 ||
        rs2alu_reorder !== 4'd2 || rs2alu_pc !== 32'h100 || rs2alu_ins_type !== 6'h01) begin
      mismatched++;
      $display("FAIL addi_issue: en=%b rs1=%0d imm=%0d rob=%0d pc=%h typ=%h required 1 5 7 2 100 01",
               rs2alu_enable, rs2alu_rs1, rs2alu_imm, rs2alu_reorder, rs2alu_pc, rs2alu_ins_type);
    end
    step();
    compared++;
    if (rs2alu_enable !== 1'b0 || rs2alu_rs1 !== 32'd0) begin
      mismatched++;
      $display("FAIL addi_single_issue: en=%b rs1=%h required 0 0", rs2alu_enable, rs2alu_rs1);
    end
  endtask

  task automatic test_alu_wakeup();
    drive_dispatch(6'h02, 1'b0, 32'd0, 4'd3, 1'b1, 32'd1, 4'd0, 32'd0, 32'h200, 4'd5);
    step();
    idle_inputs();
    step();
    step();
    compared++;
    if (rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL add_wait: en=%b required 0", rs2alu_enable);
    end
    alu2rs_bypass_enable  = 1'b1;
    alu2rs_bypass_reorder = 4'd3;
    alu2rs_bypass_value   = 32'h55;
    step();
    idle_inputs();
    compared++;
    if (rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL add_no_bypass_issue: en=%b required 0", rs2alu_enable);
    end
    step();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_rs1 !== 32'h55 || rs2alu_rs2 !== 32'd1 ||
        rs2alu_reorder !== 4'd5) begin
      mismatched++;
      $display("FAIL add_wakeup_issue: en=%b rs1=%h rs2=%h rob=%0d required 1 55 1 5",
               rs2alu_enable, rs2alu_rs1, rs2alu_rs2, rs2alu_reorder);
    end
    step();
  endtask

  task automatic test_dispatch_capture();
    drive_dispatch(6'h03, 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 4'd6, 32'd0, 32'h300, 4'd7);
    lsu2rs_bypass_enable  = 1'b1;
    lsu2rs_bypass_reorder = 4'd6;
    lsu2rs_bypass_value   = 32'hAB;
    step();
    idle_inputs();
    step();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_rs2 !== 32'hAB || rs2alu_rs1 !== 32'd9 ||
        rs2alu_reorder !== 4'd7) begin
      mismatched++;
      $display("FAIL dispatch_capture: en=%b rs1=%h rs2=%h rob=%0d required 1 9 ab 7",
               rs2alu_enable, rs2alu_rs1, rs2alu_rs2, rs2alu_reorder);
    end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      drive_dispatch(6'h04, 1'b0, 32'd0, (i == 0) ? 4'd9 : 4'd10, 1'b1, 32'd3, 4'd0,
                     32'(i), 32'h400 + 32'(i), 4'(i));
      if (i == 15) begin
        compared++;
        if (rs2dsp_full !== 1'b0) begin
          mismatched++;
          $display("FAIL full_at_15: got %b required 0", rs2dsp_full);
        end
      end
      step();
    end
    compared++;
    if (rs2dsp_full !== 1'b1) begin
      mismatched++;
      $display("FAIL full_at_16: got %b required 1", rs2dsp_full);
    end
    drive_dispatch(6'h05, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0, 32'h500, 4'd15);
    step();
    idle_inputs();
    compared++;
    if (rs2dsp_full !== 1'b1 || rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL full_drop: full=%b en=%b required 1 0", rs2dsp_full, rs2alu_enable);
    end
    alu2rs_bypass_enable  = 1'b1;
    alu2rs_bypass_reorder = 4'd9;
    alu2rs_bypass_value   = 32'h99;
    step();
    idle_inputs();
    step();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_reorder !== 4'd0 || rs2alu_rs1 !== 32'h99 ||
        rs2dsp_full !== 1'b0) begin
      mismatched++;
      $display("FAIL full_wake_entry0: en=%b rob=%0d rs1=%h full=%b required 1 0 99 0",
               rs2alu_enable, rs2alu_reorder, rs2alu_rs1, rs2dsp_full);
    end
    step();
    compared++;
    if (rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL full_dropped_not_issued: en=%b rob=%0d required 0", rs2alu_enable, rs2alu_reorder);
    end
    flush();
    compared++;
    if (rs2dsp_full !== 1'b0) begin
      mismatched++;
      $display("FAIL full_after_flush: got %b required 0", rs2dsp_full);
    end
  endtask

  task automatic test_bypass_priority();
    drive_dispatch(6'h06, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0, 32'd0, 32'h600, 4'd3);
    step();
    idle_inputs();
    alu2rs_bypass_enable  = 1'b1;
    alu2rs_bypass_reorder = 4'd4;
    alu2rs_bypass_value   = 32'h11;
    lsu2rs_bypass_enable  = 1'b1;
    lsu2rs_bypass_reorder = 4'd4;
    lsu2rs_bypass_value   = 32'h22;
    step();
    idle_inputs();
    step();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_rs1 !== 32'h11 || rs2alu_rs2 !== 32'd2) begin
      mismatched++;
      $display("FAIL alu_priority: en=%b rs1=%h rs2=%h required 1 11 2",
               rs2alu_enable, rs2alu_rs1, rs2alu_rs2);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive_dispatch(6'h07, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0, 32'd0, 32'h700, 4'd1);
    step();
    drive_dispatch(6'h08, 1'b1, 32'hC, 4'd0, 1'b1, 32'hD, 4'd0, 32'd0, 32'h704, 4'd2);
    step();
    idle_inputs();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_reorder !== 4'd1 || rs2alu_rs1 !== 32'hA) begin
      mismatched++;
      $display("FAIL b2b_first: en=%b rob=%0d rs1=%h required 1 1 a",
               rs2alu_enable, rs2alu_reorder, rs2alu_rs1);
    end
    step();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_reorder !== 4'd2 || rs2alu_rs2 !== 32'hD) begin
      mismatched++;
      $display("FAIL b2b_second: en=%b rob=%0d rs2=%h required 1 2 d",
               rs2alu_enable, rs2alu_reorder, rs2alu_rs2);
    end
    step();
    compared++;
    if (rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_drain: en=%b required 0", rs2alu_enable);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      drive_dispatch(6'h09, 1'b0, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 32'd0, 32'h800, 4'(8 + i));
      step();
    end
    drive_dispatch(6'h0A, 1'b1, 32'd4, 4'd0, 1'b1, 32'd5, 4'd0, 32'd0, 32'h810, 4'd11);
    step();
    drive_dispatch(6'h0B, 1'b1, 32'd6, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0, 32'h820, 4'd13);
    rob2rs_clear = 1'b1;
    step();
    idle_inputs();
    compared++;
    if (rs2alu_enable !== 1'b0 || rs2dsp_full !== 1'b0 || rs2alu_rs1 !== 32'd0) begin
      mismatched++;
      $display("FAIL clear_now: en=%b full=%b rs1=%h required 0 0 0",
               rs2alu_enable, rs2dsp_full, rs2alu_rs1);
    end
    alu2rs_bypass_enable  = 1'b1;
    alu2rs_bypass_reorder = 4'd12;
    alu2rs_bypass_value   = 32'h77;
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (rs2alu_enable !== 1'b0) begin
        mismatched++;
        $display("FAIL clear_quiet_%0d: en=%b rob=%0d required 0", i, rs2alu_enable, rs2alu_reorder);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    drive_dispatch(6'h0C, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 32'd0, 32'h900, 4'd14);
    step();
    drive_dispatch(6'h0D, 1'b0, 32'd0, 4'd1, 1'b1, 32'h3, 4'd0, 32'd0, 32'h904, 4'd15);
    step();
    idle_inputs();
    compared++;
    if (rs2alu_enable !== 1'b1 || rs2alu_reorder !== 4'd14) begin
      mismatched++;
      $display("FAIL pre_async_issue: en=%b rob=%0d required 1 14", rs2alu_enable, rs2alu_reorder);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (rs2alu_enable !== 1'b0 || rs2alu_reorder !== 4'd0) begin
      mismatched++;
      $display("FAIL async_reset: en=%b rob=%0d required 0 0", rs2alu_enable, rs2alu_reorder);
    end
    step();
    rst = 1'b0;
    alu2rs_bypass_enable  = 1'b1;
    alu2rs_bypass_reorder = 4'd1;
    alu2rs_bypass_value   = 32'h5;
    step();
    idle_inputs();
    step();
    compared++;
    if (rs2alu_enable !== 1'b0) begin
      mismatched++;
      $display("FAIL async_state_gone: en=%b rob=%0d required 0", rs2alu_enable, rs2alu_reorder);
    end
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_alu_wakeup();
    test_dispatch_capture();
    test_full();
    test_bypass_priority();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
